// File: rtl/lcd_grid_streamer.sv
// Streams the 10x10 game board as LCD page/column bytes over a valid/ready handshake.
// A frame goes out on a refresh request when the board changed since the last frame, or before the first frame.
module lcd_grid_streamer #(
   parameter int X_OFF  = 34,
   parameter int CELL_W = 6,
   parameter int PAGES  = 8,
   parameter int COLS   = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [99:0] game_table,
   input  logic        change,
   input  logic        en,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        busy,
   output logic        frame_done
);

   localparam int GRID     = 10;
   localparam int PW       = $clog2(PAGES);
   localparam int CW       = $clog2(COLS);
   localparam int OW       = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int GRID_END = X_OFF + GRID * CELL_W;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  page_q, nxt_page;
   logic [CW-1:0]  col_q, nxt_col;
   logic [3:0]     cell_q, nxt_cell;
   logic [OW-1:0]  off_q, nxt_off;
   logic [99:0]    shadow_q;
   logic           sent_once_q;
   logic           xfer, last_byte, nxt_in_grid;
   logic [99:0]    src_table;
   logic [7:0]     nxt_byte;

   // Two cells share a page: the even row fills bits [2:0], the odd row bits [6:4].
   function automatic logic [7:0] render(input logic [PW-1:0] p, input logic in_grid,
                                         input logic [3:0] c, input logic [OW-1:0] o,
                                         input logic [99:0] tbl);
      logic [6:0] idx;
      render = '0;
      idx    = 7'(p) * 7'd20 + 7'(c);
      if (in_grid && (p < PW'(GRID / 2)) && (o != OW'(CELL_W - 1))) begin
         render[2:0] = {3{tbl[idx]}};
         render[6:4] = {3{tbl[idx + 7'd10]}};
      end
   endfunction

   assign xfer      = data_valid && en;
   assign last_byte = (page_q == PW'(PAGES - 1)) && (col_q == CW'(COLS - 1));
   assign busy      = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
   // LOAD renders straight from the board because shadow only captures it at the end of that cycle.
   assign src_table = (state_q == LOAD) ? game_table : shadow_q;

   // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (change && (!sent_once_q || game_table != shadow_q)) state_d = LOAD;
         LOAD: state_d = SEND;
         SEND: if (xfer && last_byte) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Position of the byte to load next, with cell/offset sub-counters replacing a divider.
   always_comb begin
      nxt_page = page_q;
      nxt_col  = col_q + 1'b1;
      if (state_q == LOAD) begin
         nxt_page = '0;
         nxt_col  = '0;
      end else if (col_q == CW'(COLS - 1)) begin
         nxt_page = page_q + 1'b1;
         nxt_col  = '0;
      end

      nxt_cell = cell_q;
      nxt_off  = off_q + 1'b1;
      if (nxt_col == CW'(X_OFF)) begin
         nxt_cell = '0;
         nxt_off  = '0;
      end else if (off_q == OW'(CELL_W - 1)) begin
         nxt_cell = cell_q + 4'd1;
         nxt_off  = '0;
      end

      nxt_in_grid = (nxt_col >= CW'(X_OFF)) && ({1'b0, nxt_col} < (CW + 1)'(GRID_END));
      nxt_byte    = render(nxt_page, nxt_in_grid, nxt_cell, nxt_off, src_table);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_out    <= '0;
         data_valid  <= 1'b0;
         page_q      <= '0;
         col_q       <= '0;
         cell_q      <= '0;
         off_q       <= '0;
         // NOTE: shadow is reset because IDLE compares against it; it is a flat register, not a RAM.
         shadow_q    <= '0;
         sent_once_q <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            LOAD: begin
               shadow_q   <= game_table;
               page_q     <= nxt_page;
               col_q      <= nxt_col;
               cell_q     <= nxt_cell;
               off_q      <= nxt_off;
               data_out   <= nxt_byte;
               data_valid <= 1'b1;
            end
            SEND: begin
               if (xfer) begin
                  if (last_byte) begin
                     data_valid <= 1'b0;
                  end else begin
                     page_q   <= nxt_page;
                     col_q    <= nxt_col;
                     cell_q   <= nxt_cell;
                     off_q    <= nxt_off;
                     data_out <= nxt_byte;
                  end
               end
            end
            DONE:    sent_once_q <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_grid_streamer.sv
// Directed bench for lcd_grid_streamer: captures whole frames and compares them to a division-based pixel model.
// Also covers stalls, mid-frame board edits, refresh suppression and reset during a frame.
module tb_lcd_grid_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [99:0] game_table;
   logic        change;
   logic        en;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        busy;
   logic        frame_done;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  frame_buf [1024];

   lcd_grid_streamer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .game_table (game_table),
      .change     (change),
      .en         (en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [99:0] tbl, input int p, input int x);
      int gx, c, o;
      logic [7:0] b;
      b = 8'h00;
      if (p > 4 || x < 34 || x >= 94) return b;
      gx = x - 34;
      c  = gx / 6;
      o  = gx % 6;
      if (o == 5) return b;
      if (tbl[7'(2 * p * 10 + c)])     b[2:0] = 3'b111;
      if (tbl[7'((2 * p + 1) * 10 + c)]) b[6:4] = 3'b111;
      return b;
   endfunction

   // Captures one frame against the model of tbl; optional stall, board flip or reset at a given byte index.
   task automatic run_frame(input logic [99:0] tbl, input int stall_at, input int flip_at,
                            input int rst_at, input string tag);
      int n = 0;
      int cyc = 0;
      int stall = 0;
      logic [7:0] held = 8'h00;
      while (!data_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, " start"}, int'(data_valid), 1);
      cyc = 0;
      while (n < 1024 && cyc < 3000) begin
         if (n == rst_at) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            check({tag, " rst valid"}, int'(data_valid), 0);
            check({tag, " rst busy"}, int'(busy), 0);
            check({tag, " rst done"}, int'(frame_done), 0);
            return;
         end
         if (n == flip_at) game_table[55] = ~game_table[55];
         if (n == stall_at && stall < 5) begin
            en = 1'b0;
            if (stall > 0) begin
               check($sformatf("%s stall data %0d", tag, stall), int'(data_out), int'(held));
               check($sformatf("%s stall valid %0d", tag, stall), int'(data_valid), 1);
            end
            held = data_out;
            stall++;
         end else begin
            en = 1'b1;
            if (data_valid) begin
               frame_buf[10'(n)] = data_out;
               check($sformatf("%s p%0d c%0d", tag, n / 128, n % 128),
                     int'(data_out), int'(model_byte(tbl, n / 128, n % 128)));
               n++;
            end
         end
         tick();
         cyc++;
      end
      en = 1'b1;
      check({tag, " length"}, n, 1024);
      check({tag, " frame_done"}, int'(frame_done), 1);
      check({tag, " valid after last"}, int'(data_valid), 0);
      tick();
      check({tag, " done pulse"}, int'(frame_done), 0);
   endtask

   initial begin
      logic [99:0] t;
      bit busy_seen;
      rst_n      = 1'b0;
      en         = 1'b0;
      change     = 1'b0;
      game_table = '0;
      tick();
      tick();
      check("reset valid", int'(data_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(frame_done), 0);
      check("reset data", int'(data_out), 0);

      // First frame after reset is sent even for an empty board.
      rst_n  = 1'b1;
      change = 1'b1;
      en     = 1'b1;
      tick();
      check("load busy", int'(busy), 1);
      check("load valid", int'(data_valid), 0);
      run_frame(game_table, -1, -1, -1, "blank");
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         busy_seen |= busy | data_valid;
         tick();
      end
      check("no refresh when unchanged", int'(busy_seen), 0);

      game_table[0] = 1'b1;
      run_frame(game_table, -1, -1, -1, "cell00");
      check("cell00 c34", int'(frame_buf[34]), 8'h07);
      check("cell00 c38", int'(frame_buf[38]), 8'h07);
      check("cell00 c39", int'(frame_buf[39]), 8'h00);
      check("cell00 c33", int'(frame_buf[33]), 8'h00);

      game_table[10] = 1'b1;
      run_frame(game_table, -1, -1, -1, "cell10");
      check("cell10 c36", int'(frame_buf[36]), 8'h77);
      check("cell10 c40", int'(frame_buf[40]), 8'h00);

      game_table     = '0;
      game_table[99] = 1'b1;
      run_frame(game_table, 200, -1, -1, "cell99");
      check("cell99 c88", int'(frame_buf[4 * 128 + 88]), 8'h70);
      check("cell99 c92", int'(frame_buf[4 * 128 + 92]), 8'h70);
      check("cell99 c93", int'(frame_buf[4 * 128 + 93]), 8'h00);
      check("cell99 p5", int'(frame_buf[5 * 128 + 88]), 8'h00);

      // Board edited mid-frame: current frame keeps the snapshot, the next one shows the edit.
      game_table = '0;
      t          = game_table;
      run_frame(t, -1, 300, -1, "flip old");
      check("flip old c64", int'(frame_buf[2 * 128 + 64]), 8'h00);
      t = game_table;
      run_frame(t, -1, -1, -1, "flip new");
      check("flip new c64", int'(frame_buf[2 * 128 + 64]), 8'h70);
      check("flip new c68", int'(frame_buf[2 * 128 + 68]), 8'h70);
      check("flip new c69", int'(frame_buf[2 * 128 + 69]), 8'h00);

      // Reset in the middle of a frame, then a full restart from page 0 col 0.
      game_table[0] = 1'b1;
      run_frame(game_table, -1, -1, 500, "abort");
      run_frame(game_table, -1, -1, -1, "restart");
      check("restart c34", int'(frame_buf[34]), 8'h07);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_grid_streamer.md
Name: lcd_grid_streamer

Overview:
Renders the 100-bit game board (10x10 cells) into the byte stream LCD_control consumes: 8 pages x 128 columns, one byte per column per page, each bit one vertical pixel. It replaces the fixed RAM_ctrl path between GameRAMControll (game_table_output) and LCD_control (data/data_valid/en_tran). A new frame is sent only when refresh is requested and the board has changed since the last frame sent, or when no frame has been sent since reset.

Parameters:
X_OFF, 34, first LCD column of the grid (0..68)
CELL_W, 6, pixel columns per cell; the last column of each cell is a blank gap
PAGES, 8, pages per frame
COLS, 128, columns per page

Ports:
clk  in  1  system clock (the clk_div domain)
rst_n  in  1  synchronous active-low reset
game_table  in  100  board; cell (r,c) = game_table[r*10+c], 1 = filled
change  in  1  refresh request, level-sensitive
en  in  1  ready from LCD_control (en_tran)
data_out  out  8  pixel byte, bit0 = top pixel of page
data_valid  out  1  data_out holds a valid byte
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last byte of a frame transfers

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; data_out=0, data_valid=0, busy=0, frame_done=0; page=0, col=0; shadow=0; sent_once=0. Reset mid-frame aborts the frame immediately with no further valid.
- States: IDLE, LOAD, SEND, DONE.
- IDLE: if change && (!sent_once || game_table != shadow), go to LOAD. Otherwise stay.
- LOAD (1 cycle):
  - shadow <= game_table; page=0, col=0.
  - Register byte(0,0) into data_out and set data_valid=1.
  - busy=1 from LOAD through DONE.
- SEND uses valid/ready handshake:
  - A transfer occurs in any cycle where data_valid && en.
  - With en=0, data_out and data_valid are held unchanged.
  - On transfer, advance col; at col=COLS-1, wrap col to 0 and increment page.
  - Load the next byte in the same cycle, so throughput is 1 byte/cycle when en stays high.
  - On transfer of byte (PAGES-1, COLS-1): data_valid<=0, go to DONE.
- DONE (1 cycle): frame_done=1, sent_once<=1, busy<=0, go to IDLE.
- change and game_table edits during LOAD/SEND/DONE are ignored; only shadow is rendered. If the board differs at return to IDLE, a new frame starts when change is high.
- Byte rendering, byte(p,x):
  - 0x00 if p>4 or x<X_OFF or x>=X_OFF+10*CELL_W.
  - Otherwise gx=x-X_OFF, c=gx/CELL_W, o=gx%CELL_W.
  - If o==CELL_W-1, the byte is 0x00 (gap).
  - Otherwise bits[2:0]=3'b111 if shadow cell (2p,c) is set; bits[6:4]=3'b111 if cell (2p+1,c) is set; bits 3 and 7 are always 0.
  - c and o come from incrementing sub-counters reset at x=X_OFF. No divider is used.
- Frame length is exactly PAGES*COLS=1024 transfers. There is never an extra or missing byte.

Test Plan:
- Reset, table=0, change=1, en=1 -> LOAD 1 cycle after change sampled, then 1024 consecutive transfers all 0x00, frame_done pulse; keep change=1, table unchanged -> no second frame, busy stays 0.
- Cell (0,0) set -> page0 cols 34..38 = 0x07, col39 = 0x00, all other bytes 0x00; cell (1,0) also set -> cols 34..38 = 0x77.
- Cell (9,9) only -> page4 cols 88..92 = 0x70, col93 = 0x00, pages 5..7 all 0x00.
- en toggled low for 5 cycles at byte 200 -> data_out/data_valid stable during stall; total transfers still 1024 with correct sequence.
- Flip game_table bit 55 mid-frame -> current frame renders old shadow; after frame_done, with change=1, a second frame starts showing cell (5,5): page2 cols 64..68 = 0x70.
- rst_n low for 1 cycle at byte 500 -> next cycle data_valid=0, busy=0; with change=1, a full frame restarts from page0 col0.
